// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard read-modify-write sequencer.
package placar_pkg;

   localparam int LARGURA_PADRAO    = 8;
   localparam int MAX_PLACAR_PADRAO = 199;

   // Sequencer phases: arbitrate, read, add, wait for register capture, verify.
   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      LE       = 3'd1,
      SOMA     = 3'd2,
      ESCREVE  = 3'd3,
      VERIFICA = 3'd4
   } estado_t;

   // Point opcodes coming from the button logic.
   localparam logic [1:0] PONTO_ESTORNO = 2'b00;
   localparam logic [1:0] PONTO_1       = 2'b01;
   localparam logic [1:0] PONTO_2       = 2'b10;
   localparam logic [1:0] PONTO_3       = 2'b11;

   // Which score register(s) the current operation touches.
   typedef enum logic [1:0] {
      ALVO_A     = 2'd0,
      ALVO_B     = 2'd1,
      ALVO_AMBOS = 2'd2
   } alvo_t;

endpackage

// File: rtl/somador_saturado.sv
// Shared score adder: +1/+2/+3 clamped at the ceiling, estorno floored at zero.
module somador_saturado
   import placar_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic [LARGURA-1:0] atual,
   input  logic [1:0]         pontos,
   input  logic [LARGURA-1:0] max,
   output logic [LARGURA-1:0] resultado
);

   // Two extra bits so the sum can never wrap before it is clamped.
   logic [LARGURA+1:0] soma_larga;

   // Select between floored decrement and clamped increment.
   always_comb begin
      soma_larga = {2'b00, atual} + {{LARGURA{1'b0}}, pontos};
      resultado  = atual;
      if (pontos == PONTO_ESTORNO) begin
         resultado = (atual == '0) ? '0 : (atual - LARGURA'(1));
      end else if (soma_larga > {2'b00, max}) begin
         resultado = max;
      end else begin
         resultado = soma_larga[LARGURA-1:0];
      end
   end

endmodule

// File: rtl/placar_controlador.sv
// Arbitrates team A/B point requests and clears, runs one read-add-write-verify
// pass per operation through a single shared saturating adder.
module placar_controlador
   import placar_pkg::*;
#(
   parameter int                 LARGURA    = LARGURA_PADRAO,
   parameter logic [LARGURA-1:0] MAX_PLACAR = LARGURA'(MAX_PLACAR_PADRAO)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_a,
   input  logic [1:0]         pontos_a,
   input  logic               req_b,
   input  logic [1:0]         pontos_b,
   input  logic               zerar,
   input  logic [LARGURA-1:0] saida_a,
   input  logic [LARGURA-1:0] saida_b,
   output logic [LARGURA-1:0] entrada_a,
   output logic [LARGURA-1:0] entrada_b,
   output logic               ack_a,
   output logic               ack_b,
   output logic               ack_zerar,
   output logic               ocupado,
   output logic               erro_a,
   output logic               erro_b
);

   estado_t            estado_q, estado_d;
   alvo_t              alvo_q, alvo_d;
   alvo_t              ultimo_q, ultimo_d;
   logic [1:0]         pontos_q, pontos_d;
   logic [LARGURA-1:0] atual_q, atual_d;
   logic [LARGURA-1:0] resultado_q, resultado_d;
   logic [LARGURA-1:0] entrada_a_q, entrada_a_d;
   logic [LARGURA-1:0] entrada_b_q, entrada_b_d;
   logic               erro_a_q, erro_a_d;
   logic               erro_b_q, erro_b_d;
   logic [LARGURA-1:0] soma;

   somador_saturado #(.LARGURA(LARGURA)) u_somador (
      .atual     (atual_q),
      .pontos    (pontos_q),
      .max       (MAX_PLACAR),
      .resultado (soma)
   );

   // Next-state logic: arbitration in OCIOSO, then the fixed four-step pass.
   always_comb begin
      estado_d    = estado_q;
      alvo_d      = alvo_q;
      ultimo_d    = ultimo_q;
      pontos_d    = pontos_q;
      atual_d     = atual_q;
      resultado_d = resultado_q;
      entrada_a_d = entrada_a_q;
      entrada_b_d = entrada_b_q;
      erro_a_d    = erro_a_q;
      erro_b_d    = erro_b_q;
      case (estado_q)
         OCIOSO: begin
            // Clear wins; pending reqs stay high and are served afterwards.
            if (zerar) begin
               alvo_d   = ALVO_AMBOS;
               estado_d = LE;
            end else if (req_a && (!req_b || ultimo_q == ALVO_B)) begin
               alvo_d   = ALVO_A;
               ultimo_d = ALVO_A;
               pontos_d = pontos_a;
               estado_d = LE;
            end else if (req_b) begin
               alvo_d   = ALVO_B;
               ultimo_d = ALVO_B;
               pontos_d = pontos_b;
               estado_d = LE;
            end
         end
         LE: begin
            atual_d  = (alvo_q == ALVO_B) ? saida_b : saida_a;
            estado_d = SOMA;
         end
         SOMA: begin
            resultado_d = (alvo_q == ALVO_AMBOS) ? '0 : soma;
            if (alvo_q != ALVO_B) entrada_a_d = resultado_d;
            if (alvo_q != ALVO_A) entrada_b_d = resultado_d;
            estado_d = ESCREVE;
         end
         ESCREVE: begin
            // The score register captures entrada at the end of this cycle.
            estado_d = VERIFICA;
         end
         VERIFICA: begin
            if (alvo_q != ALVO_B && saida_a != resultado_q) erro_a_d = 1'b1;
            if (alvo_q != ALVO_A && saida_b != resultado_q) erro_b_d = 1'b1;
            estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // State and output registers; reset aborts any pass and zeroes the drives.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q    <= OCIOSO;
         alvo_q      <= ALVO_A;
         ultimo_q    <= ALVO_B;
         pontos_q    <= PONTO_ESTORNO;
         atual_q     <= '0;
         resultado_q <= '0;
         entrada_a_q <= '0;
         entrada_b_q <= '0;
         erro_a_q    <= 1'b0;
         erro_b_q    <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         alvo_q      <= alvo_d;
         ultimo_q    <= ultimo_d;
         pontos_q    <= pontos_d;
         atual_q     <= atual_d;
         resultado_q <= resultado_d;
         entrada_a_q <= entrada_a_d;
         entrada_b_q <= entrada_b_d;
         erro_a_q    <= erro_a_d;
         erro_b_q    <= erro_b_d;
      end
   end

   assign entrada_a = entrada_a_q;
   assign entrada_b = entrada_b_q;
   assign erro_a    = erro_a_q;
   assign erro_b    = erro_b_q;
   assign ocupado   = (estado_q != OCIOSO);
   assign ack_a     = (estado_q == VERIFICA) && (alvo_q == ALVO_A);
   assign ack_b     = (estado_q == VERIFICA) && (alvo_q == ALVO_B);
   assign ack_zerar = (estado_q == VERIFICA) && (alvo_q == ALVO_AMBOS);

endmodule
